// File: rtl/pc_sequencer.sv
// pc_sequencer
// Multi-cycle fetch/execute sequencer that owns the program counter of the CPU.
// It walks IDLE -> FETCH -> EXEC (-> MEMWAIT) -> FETCH, holding the PC while
// instruction or data memory reports busywait, and resolves the next PC from
// the control unit's jump/branch decodes and the ALU ZERO flag.
//
// Ports:
//   CLK            clock, all state changes on the rising edge
//   RESET          asynchronous active-low reset
//   JSIGNAL        jump decoded
//   BEQSIGNAL      beq decoded
//   BNESIGNAL      bne decoded
//   ZERO           ALU zero flag for the current instruction
//   OFFSET         signed instruction-count offset from the instruction word
//   INSTR_BUSYWAIT instruction memory not ready
//   DATA_BUSYWAIT  data memory/cache not ready
//   PC             current instruction address
//   INSTR_READ     instruction fetch request (FETCH state)
//   EXEC_EN        execute cycle; qualifies register-file write enable
//   STALL          sequencer waiting on a memory
//   BRANCH_TAKEN   one-cycle pulse after an EXEC that redirected the PC
module pc_sequencer #(
  parameter int                  PC_WIDTH     = 32,
  parameter int                  OFFSET_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    JSIGNAL,
  input  logic                    BEQSIGNAL,
  input  logic                    BNESIGNAL,
  input  logic                    ZERO,
  input  logic [OFFSET_WIDTH-1:0] OFFSET,
  input  logic                    INSTR_BUSYWAIT,
  input  logic                    DATA_BUSYWAIT,
  output logic [PC_WIDTH-1:0]     PC,
  output logic                    INSTR_READ,
  output logic                    EXEC_EN,
  output logic                    STALL,
  output logic                    BRANCH_TAKEN
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    EXEC    = 2'd2,
    MEMWAIT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] npc_q, npc_d;
  logic                branchTaken_q, branchTaken_d;

  logic [PC_WIDTH-1:0] plus4;
  logic [PC_WIDTH-1:0] offsetExt;
  logic [PC_WIDTH-1:0] target;
  logic                takeTarget;
  logic [PC_WIDTH-1:0] nextPc;

  // Next-PC resolution. The offset counts instructions, so it is sign-extended
  // to the PC width and scaled by 4; all sums wrap silently at 2^PC_WIDTH.
  // The priority chain means beq wins whenever beq and bne are both asserted.
  always_comb begin
    plus4      = pc_q + PC_WIDTH'(4);
    offsetExt  = PC_WIDTH'(signed'(OFFSET));
    target     = plus4 + (offsetExt << 2);
    takeTarget = 1'b0;
    if (JSIGNAL) begin
      takeTarget = 1'b1;
    end else if (BEQSIGNAL) begin
      takeTarget = ZERO;
    end else if (BNESIGNAL) begin
      takeTarget = ~ZERO;
    end
    nextPc = takeTarget ? target : plus4;
  end

  // Next-state logic. A data busywait during EXEC parks the resolved PC in
  // npc_q so MEMWAIT can ignore the (by then stale) branch inputs.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    npc_d         = npc_q;
    branchTaken_d = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (!INSTR_BUSYWAIT) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (DATA_BUSYWAIT) begin
          npc_d   = nextPc;
          state_d = MEMWAIT;
        end else begin
          pc_d          = nextPc;
          branchTaken_d = takeTarget;
          state_d       = FETCH;
        end
      end
      MEMWAIT: begin
        if (!DATA_BUSYWAIT) begin
          pc_d    = npc_q;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset acts immediately so no partial PC update survives.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      npc_q         <= RESET_PC;
      branchTaken_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      npc_q         <= npc_d;
      branchTaken_q <= branchTaken_d;
    end
  end

  // Moore outputs, except STALL in FETCH which follows INSTR_BUSYWAIT directly.
  always_comb begin
    INSTR_READ = 1'b0;
    EXEC_EN    = 1'b0;
    STALL      = 1'b0;
    case (state_q)
      FETCH: begin
        INSTR_READ = 1'b1;
        STALL      = INSTR_BUSYWAIT;
      end
      EXEC: begin
        EXEC_EN = 1'b1;
      end
      MEMWAIT: begin
        STALL = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign PC           = pc_q;
  assign BRANCH_TAKEN = branchTaken_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: reset, sequential fetch, branches,
// instruction/data stalls, asynchronous reset during MEMWAIT and PC wrap.
module tb_pc_sequencer;

  logic        CLK;
  logic        RESET;
  logic        JSIGNAL;
  logic        BEQSIGNAL;
  logic        BNESIGNAL;
  logic        ZERO;
  logic [7:0]  OFFSET;
  logic        INSTR_BUSYWAIT;
  logic        DATA_BUSYWAIT;
  logic [31:0] PC;
  logic        INSTR_READ;
  logic        EXEC_EN;
  logic        STALL;
  logic        BRANCH_TAKEN;

  int errors = 0;
  int checks = 0;

  pc_sequencer #(
    .PC_WIDTH    (32),
    .OFFSET_WIDTH(8),
    .RESET_PC    (32'h0)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .JSIGNAL       (JSIGNAL),
    .BEQSIGNAL     (BEQSIGNAL),
    .BNESIGNAL     (BNESIGNAL),
    .ZERO          (ZERO),
    .OFFSET        (OFFSET),
    .INSTR_BUSYWAIT(INSTR_BUSYWAIT),
    .DATA_BUSYWAIT (DATA_BUSYWAIT),
    .PC            (PC),
    .INSTR_READ    (INSTR_READ),
    .EXEC_EN       (EXEC_EN),
    .STALL         (STALL),
    .BRANCH_TAKEN  (BRANCH_TAKEN)
  );

  // 10 ns clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one rising edge and settle 1 ns so outputs are sampled off the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive the decode/branch inputs for the coming edge.
  task automatic applyStimulus(input logic j, input logic beq, input logic bne,
                               input logic z, input logic [7:0] off,
                               input logic ibusy, input logic dbusy);
    JSIGNAL        = j;
    BEQSIGNAL      = beq;
    BNESIGNAL      = bne;
    ZERO           = z;
    OFFSET         = off;
    INSTR_BUSYWAIT = ibusy;
    DATA_BUSYWAIT  = dbusy;
  endtask

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Full output snapshot: pc, instr_read, exec_en, stall, branch_taken.
  task automatic checkAll(input string tag, input logic [31:0] pc, input logic ir,
                          input logic ee, input logic st, input logic bt);
    checkOutput({tag, ".pc"}, PC, pc);
    checkOutput({tag, ".instr_read"}, {31'b0, INSTR_READ}, {31'b0, ir});
    checkOutput({tag, ".exec_en"}, {31'b0, EXEC_EN}, {31'b0, ee});
    checkOutput({tag, ".stall"}, {31'b0, STALL}, {31'b0, st});
    checkOutput({tag, ".branch_taken"}, {31'b0, BRANCH_TAKEN}, {31'b0, bt});
  endtask

  initial begin
    RESET = 1'b0;
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 0);

    // Reset held for 3 cycles.
    tick(); tick(); tick();
    checkAll("reset", 32'h0, 0, 0, 0, 0);

    // Release: IDLE cycle, then FETCH, then EXEC.
    RESET = 1'b1;
    #1;
    checkAll("idle", 32'h0, 0, 0, 0, 0);
    tick();
    checkAll("fetch0", 32'h0, 1, 0, 0, 0);
    tick();
    checkAll("exec0", 32'h0, 0, 1, 0, 0);

    // Sequential flow, 2 cycles per instruction.
    tick();
    checkAll("fetch4", 32'h4, 1, 0, 0, 0);
    tick();
    checkAll("exec4", 32'h4, 0, 1, 0, 0);
    tick();
    checkAll("fetch8", 32'h8, 1, 0, 0, 0);
    tick();
    checkAll("exec8", 32'h8, 0, 1, 0, 0);

    // beq taken at PC=8, offset 2 -> 8+4+8 = 20.
    applyStimulus(0, 1, 0, 1, 8'h02, 0, 0);
    tick();
    checkAll("beq_taken", 32'd20, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 0);
    tick();
    checkAll("beq_pulse_end", 32'd20, 0, 1, 0, 0);

    // j from 20 with -4 -> 24-16 = 8.
    applyStimulus(1, 0, 0, 0, 8'hFC, 0, 0);
    tick();
    checkAll("j_back8a", 32'd8, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 0);
    tick();

    // beq not taken at PC=8 -> 12.
    applyStimulus(0, 1, 0, 0, 8'h02, 0, 0);
    tick();
    checkAll("beq_not_taken", 32'd12, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 0);
    tick();

    // j from 12 with -2 -> 16-8 = 8.
    applyStimulus(1, 0, 0, 0, 8'hFE, 0, 0);
    tick();
    checkOutput("j_back8b.pc", PC, 32'd8);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 0);
    tick();

    // bne taken at PC=8 -> 20.
    applyStimulus(0, 0, 1, 0, 8'h02, 0, 0);
    tick();
    checkAll("bne_taken", 32'd20, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 0);
    tick();

    // bne with ZERO=1 at PC=20 falls through -> 24.
    applyStimulus(0, 0, 1, 1, 8'h02, 0, 0);
    tick();
    checkAll("bne_not_taken", 32'd24, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 0);
    tick();

    // j from 24 with -5 -> 28-20 = 8, then j at PC=8 with -2 -> 4.
    applyStimulus(1, 0, 0, 0, 8'hFB, 0, 0);
    tick();
    checkOutput("j_back8c.pc", PC, 32'd8);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 8'hFE, 0, 0);
    tick();
    checkAll("j_back4", 32'd4, 1, 0, 0, 1);

    // Instruction busywait: 3 stalled FETCH cycles, PC held.
    applyStimulus(0, 0, 0, 0, 8'h00, 1, 0);
    #1;
    checkAll("ibusy1", 32'd4, 1, 0, 1, 1);
    tick();
    checkAll("ibusy2", 32'd4, 1, 0, 1, 0);
    tick();
    checkAll("ibusy3", 32'd4, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 0);
    #1;
    checkOutput("ibusy_release.stall", {31'b0, STALL}, 32'd0);
    tick();
    checkAll("exec_after_ibusy", 32'd4, 0, 1, 0, 0);

    // Data busywait with j offset 2 at PC=4 -> NPC = 16; 4 MEMWAIT cycles.
    applyStimulus(1, 0, 0, 0, 8'h02, 0, 1);
    tick();
    checkAll("memwait1", 32'd4, 0, 0, 1, 0);
    // Branch inputs changed during MEMWAIT must be ignored.
    applyStimulus(0, 1, 0, 1, 8'h10, 0, 1);
    tick();
    checkAll("memwait2", 32'd4, 0, 0, 1, 0);
    tick();
    checkAll("memwait3", 32'd4, 0, 0, 1, 0);
    tick();
    checkAll("memwait4", 32'd4, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 0);
    tick();
    checkAll("after_memwait", 32'd16, 1, 0, 0, 0);
    tick();

    // j from 16 with +11 -> 20+44 = 0x40, then busy EXEC at 0x40 -> MEMWAIT.
    applyStimulus(1, 0, 0, 0, 8'h0B, 0, 0);
    tick();
    checkAll("jump_40", 32'h40, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 1);
    tick();
    checkAll("memwait_40", 32'h40, 0, 0, 1, 0);

    // Asynchronous reset mid-cycle.
    #2;
    RESET = 1'b0;
    #1;
    checkAll("async_reset", 32'h0, 0, 0, 0, 0);
    tick();
    RESET = 1'b1;
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 0);
    #1;
    checkAll("idle_after_reset", 32'h0, 0, 0, 0, 0);
    tick();
    checkAll("refetch0", 32'h0, 1, 0, 0, 0);
    tick();
    checkAll("reexec0", 32'h0, 0, 1, 0, 0);

    // Wrap: j at PC=0 with -2 -> 4-8 = 0xFFFFFFFC, then sequential -> 0.
    applyStimulus(1, 0, 0, 0, 8'hFE, 0, 0);
    tick();
    checkAll("wrap_target", 32'hFFFF_FFFC, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 0);
    tick();
    tick();
    checkAll("wrap_seq", 32'h0, 1, 0, 0, 0);

    // Self-loop: OFFSET=0xFF at PC=0 -> TARGET = PC.
    tick();
    applyStimulus(1, 0, 0, 0, 8'hFF, 0, 0);
    tick();
    checkAll("self_loop", 32'h0, 1, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
